// File: rtl/instruction_fetch_if.sv
// Avalon-style read-only memory bus used by the instruction fetch stage.
// The master drives the address, strobe and byte enables; the slave returns stall and data.
interface instruction_fetch_if;
   logic [31:0] mem_address;
   logic        mem_read;
   logic [3:0]  mem_byteenable;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;

   modport master (
      output mem_address,
      output mem_read,
      output mem_byteenable,
      input  mem_waitrequest,
      input  mem_readdata
   );

   modport slave (
      input  mem_address,
      input  mem_read,
      input  mem_byteenable,
      output mem_waitrequest,
      output mem_readdata
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one word read per fetch request, held in a byte-ordered instruction register
// with decoded fields; a fetch from HALT_ADDRESS parks the stage until reset.
module instruction_fetch #(
   parameter bit          SWAP_BYTES   = 1'b1,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] HALT_ADDRESS = 32'h0000_0000
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_fetch_req,
   input  logic [31:0]         i_pc_address,
   instruction_fetch_if.master bus,
   output logic                o_instr_valid,
   output logic                o_busy,
   output logic [31:0]         o_instr,
   output logic [5:0]          o_opcode,
   output logic [4:0]          o_rs,
   output logic [4:0]          o_rt,
   output logic [4:0]          o_rd,
   output logic [4:0]          o_shamt,
   output logic [5:0]          o_funct,
   output logic [15:0]         o_offset,
   output logic [25:0]         o_instr_index,
   output logic                o_active
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_DATA = 2'd2,
      ST_HALTED    = 2'd3
   } state_t;

   // Counter holds the remaining cycles after acceptance, so it is loaded with latency-1.
   localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

   function automatic logic [31:0] f_byte_swap(input logic [31:0] d);
      f_byte_swap = {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_mem_address;
   logic [31:0] w_mem_address;
   logic        r_mem_read;
   logic        w_mem_read;
   logic [3:0]  r_byteenable;
   logic [1:0]  r_lat_cnt;
   logic [1:0]  w_lat_cnt;
   logic [31:0] r_instr;
   logic [31:0] w_instr;
   logic        r_instr_valid;
   logic        w_instr_valid;
   logic        r_busy;
   logic        w_busy;
   logic        r_active;
   logic        w_active;
   logic [31:0] w_load_data;

   assign w_load_data = SWAP_BYTES ? f_byte_swap(bus.mem_readdata) : bus.mem_readdata;

   // Next-state and next-register-value logic for the fetch sequencer.
   always_comb begin
      w_next_state  = r_state;
      w_mem_address = r_mem_address;
      w_mem_read    = r_mem_read;
      w_lat_cnt     = r_lat_cnt;
      w_instr       = r_instr;
      w_instr_valid = 1'b0;
      w_busy        = r_busy;
      w_active      = r_active;
      case (r_state)
         ST_IDLE: begin
            if (i_fetch_req) begin
               if (i_pc_address == HALT_ADDRESS) begin
                  w_next_state = ST_HALTED;
                  w_active     = 1'b0;
                  w_busy       = 1'b0;
               end else begin
                  w_next_state  = ST_REQ;
                  w_mem_address = {i_pc_address[31:2], 2'b00};
                  w_mem_read    = 1'b1;
                  w_busy        = 1'b1;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!bus.mem_waitrequest) begin
               w_next_state = ST_WAIT_DATA;
               w_mem_read   = 1'b0;
               w_lat_cnt    = LAT_LOAD;
            end else begin
               w_next_state = ST_REQ;
            end
         end
         ST_WAIT_DATA: begin
            if (r_lat_cnt == 2'd0) begin
               w_next_state  = ST_IDLE;
               w_instr       = w_load_data;
               w_instr_valid = 1'b1;
               w_busy        = 1'b0;
            end else begin
               w_lat_cnt = r_lat_cnt - 2'd1;
            end
         end
         ST_HALTED: begin
            w_next_state = ST_HALTED;
            w_mem_read   = 1'b0;
            w_busy       = 1'b0;
            w_active     = 1'b0;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_mem_read   = 1'b0;
            w_busy       = 1'b0;
         end
      endcase
   end

   // State and output registers; reset also abandons any read still in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_mem_address <= 32'h0000_0000;
         r_mem_read    <= 1'b0;
         r_byteenable  <= 4'hF;
         r_lat_cnt     <= 2'd0;
         r_instr       <= 32'h0000_0000;
         r_instr_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_active      <= 1'b1;
      end else begin
         r_state       <= w_next_state;
         r_mem_address <= w_mem_address;
         r_mem_read    <= w_mem_read;
         r_byteenable  <= 4'hF;
         r_lat_cnt     <= w_lat_cnt;
         r_instr       <= w_instr;
         r_instr_valid <= w_instr_valid;
         r_busy        <= w_busy;
         r_active      <= w_active;
      end
   end

   assign bus.mem_address    = r_mem_address;
   assign bus.mem_read       = r_mem_read;
   assign bus.mem_byteenable = r_byteenable;

   assign o_instr_valid = r_instr_valid;
   assign o_busy        = r_busy;
   assign o_active      = r_active;
   assign o_instr       = r_instr;
   assign o_opcode      = r_instr[31:26];
   assign o_rs          = r_instr[25:21];
   assign o_rt          = r_instr[20:16];
   assign o_rd          = r_instr[15:11];
   assign o_shamt       = r_instr[10:6];
   assign o_funct       = r_instr[5:0];
   assign o_offset      = r_instr[15:0];
   assign o_instr_index = r_instr[25:0];

endmodule
